ram_nibble_writer: RTL and testbench
====================================

# ram_nibble_writer

Front-panel entry block that assembles a 16-bit word from four 4-bit switch nibbles, one nibble per pushbutton press. It writes the completed word into port A of the on-chip RAM, reads it back and flags mismatches. It is the writing end of the RAM interface whose read side drives the hex displays. The `entry` output feeds the same four hex-to-7-segment decoders so the operator sees the word as it is built.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width; the address wraps at 2^ADDR_W.
- `RD_LAT`, 1: RAM read latency in clocks (address registered to `q_a` valid); legal range 1..3.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `sw`  in  4  nibble to enter; sampled on an accepted press.
- `addr_rst`  in  1  synchronous, active-high; restarts entry at address 0.
- `q_a`  in  16  RAM port-A read data.
- `addr_a`  out  ADDR_W  RAM port-A address.
- `data_a`  out  16  RAM port-A write data; always equals `entry`.
- `we_a`  out  1  RAM port-A write enable.
- `entry`  out  16  word being assembled, or last word written.
- `nib_idx`  out  2  count of nibbles entered toward the current word.
- `busy`  out  1  high while in the WRITE, RDWAIT or CHECK states.
- `verify_err`  out  1  sticky; set on a read-back mismatch.

## Operation
- **Reset:** async reset forces `state`=COLLECT. It also clears `addr_a`, `entry`, `nib_idx`, `we_a`, `busy`, `verify_err`, the synchronizer flops and the `RD_LAT` counter to 0.
- **Key conditioning:**
  - `key_n` passes through a 2-flop synchronizer.
  - A falling edge of the synchronized signal produces a registered one-cycle pulse, `press`.
  - There is no debounce; the bench drives clean edges.
- **COLLECT state:**
  - On `press`: `entry` <= {`entry`[11:0], `sw`}. The first nibble entered ends up as the most significant nibble.
  - If `nib_idx`==3, `nib_idx` <= 0 and the state goes to WRITE. Otherwise `nib_idx` increments.
- **WRITE state:** `we_a`=1 for exactly one cycle, with the current `addr_a` and `data_a`. Next state is RDWAIT.
- **RDWAIT state:** `we_a`=0 and `addr_a` is held. Stays for `RD_LAT` cycles, then goes to CHECK.
- **CHECK state:**
  - If `q_a` != `entry`, `verify_err` <= 1.
  - `addr_a` <= `addr_a`+1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0 with no flag).
  - Next state is COLLECT.
- **Press while busy:** a `press` arriving in WRITE, RDWAIT or CHECK is dropped. It is not queued.
- **`addr_rst`:**
  - Honored only in COLLECT: `addr_a`<=0, `nib_idx`<=0, `verify_err`<=0; `entry` is unchanged.
  - If `addr_rst` and `press` occur in the same cycle, `addr_rst` wins and the press is dropped.
  - `addr_rst` is ignored while `busy`.
- **`entry` after a write:** holds the written word until the next press shifts in new nibbles.
- **Reset mid-write:** reset asserted during WRITE or RDWAIT aborts the operation. `we_a` drops immediately (asynchronously). The RAM content at that address is undefined.

## Timing
- **Press latency:** `key_n` sampled low at edge k gives `press` high in the cycle after edge k+2. `entry` and `nib_idx` update at edge k+3.
- **Write start:** the fourth accepted press moves the state to WRITE at the same edge. `we_a` is high for the following single cycle.
- **Busy duration:** `busy` is high for exactly 2+`RD_LAT` cycles. Back in COLLECT, the incremented `addr_a` is visible.
- **Outputs:** all outputs are registered except `data_a`, which is a wire copy of `entry`. There are no combinational paths from inputs to outputs.
- **Throughput:** at most one word per 4 presses. The minimum press spacing is 2 cycles (one falling edge needs a high sample in between).

## Structure
- **Shared package (`ram_if_pkg`):** the state encoding (COLLECT, WRITE, RDWAIT, CHECK), `DATA_W`=16, and the default `ADDR_W`. The read-side FSM imports the same package.
- **Sub-module `key_edge_sync`:** 2-flop synchronizer plus registered falling-edge pulse. Ports: `clk`, `reset_n`, `key_n`, `press`. It will be reused for the display step button.
- **Top:** the FSM, datapath registers and the `RD_LAT` down-counter.

## Test plan
- **Reset:** assert `reset_n`=0 mid-stream. All outputs are 0, the state is COLLECT, and `we_a` falls without waiting for a clock.
- **Basic entry:** press with `sw`=A,B,C,D. `entry` steps 000A, 00AB, 0ABC, ABCD. `we_a` pulses once with `addr_a`=0 and `data_a`=ABCD. After CHECK, `addr_a`=1 and `verify_err`=0.
- **Read-back mismatch:** the RAM model returns 1234 for a write of ABCD. `verify_err`=1 and stays set through the next good word. `addr_rst` in COLLECT clears it.
- **Drop while busy:** press during `busy`. The press is dropped; `nib_idx` and `entry` are unchanged after `busy` falls.
- **Address wrap:** with `ADDR_W`=2, write 5 words. Addresses used are 0,1,2,3,0; the fifth write overwrites address 0.
- **Simultaneous `addr_rst` and `press`:** assert both in the same cycle with `nib_idx`=2. Result: `nib_idx`=0, `addr_a`=0, `entry` unchanged. Repeat with `RD_LAT`=3 and confirm `busy` lasts 5 cycles.

Source files
------------

// File: rtl/ram_if_pkg.sv
// ram_if_pkg: shared state encoding and widths for the RAM entry/display FSMs.
// No ports; imported by writer and reader sides.
package ram_if_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    RDWAIT  = 2'd2,
    CHECK   = 2'd3
  } state_t;

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer plus registered falling-edge pulse.
// Ports: clk, reset_n (async low), key_n (raw, active low), press (1-cycle).
module key_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_press;

  // r_s3 is the previous synchronized sample, used only for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= key_n;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_press <= r_s3 & ~r_s2;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/ram_nibble_writer.sv
// ram_nibble_writer: builds 16-bit words from 4 switch nibbles, writes/verifies RAM port A.
// Ports: clk, reset_n, key_n, sw, addr_rst, q_a -> addr_a, data_a, we_a, entry, nib_idx, busy, verify_err.
module ram_nibble_writer
  import ram_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_n,
  input  logic [3:0]        sw,
  input  logic              addr_rst,
  input  logic [DATA_W-1:0] q_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_a,
  output logic              we_a,
  output logic [DATA_W-1:0] entry,
  output logic [1:0]        nib_idx,
  output logic              busy,
  output logic              verify_err
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        r_nib;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_entry;
  logic              r_we;
  logic              r_busy;
  logic              r_err;
  logic              w_press;

  key_edge_sync u_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .press   (w_press)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (!addr_rst && w_press && r_nib == 2'd3)
          w_nxt = WRITE;
      end
      WRITE:   w_nxt = RDWAIT;
      RDWAIT:  if (r_cnt == 2'd0) w_nxt = CHECK;
      CHECK:   w_nxt = COLLECT;
      default: w_nxt = COLLECT;
    endcase
  end

  // we_a/busy are registered from the next state so they line up
  // with the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= COLLECT;
      r_cnt   <= 2'd0;
      r_nib   <= 2'd0;
      r_addr  <= '0;
      r_entry <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_we    <= (w_nxt == WRITE);
      r_busy  <= (w_nxt != COLLECT);
      case (r_state)
        COLLECT: begin
          if (addr_rst) begin
            r_addr <= '0;
            r_nib  <= 2'd0;
            r_err  <= 1'b0;
          end else if (w_press) begin
            r_entry <= {r_entry[11:0], sw};
            r_nib   <= r_nib + 2'd1;
          end
        end
        WRITE:  r_cnt <= LAT_M1;
        RDWAIT: if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
        CHECK: begin
          if (q_a != r_entry) r_err <= 1'b1;
          r_addr <= r_addr + 1'b1;
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign addr_a     = r_addr;
  assign data_a     = r_entry;
  assign we_a       = r_we;
  assign entry      = r_entry;
  assign nib_idx    = r_nib;
  assign busy       = r_busy;
  assign verify_err = r_err;

endmodule

// File: tb/tb_ram_nibble_writer.sv
// tb_ram_nibble_writer: directed tables plus randomized model check of the nibble writer.
// Instance A: ADDR_W=2, RD_LAT=1. Instance B: ADDR_W=10, RD_LAT=3.
module tb_ram_nibble_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_key = 1'b1, b_key = 1'b1;
  logic [3:0]  a_sw = '0, b_sw = '0;
  logic        a_arst = 1'b0, b_arst = 1'b0;
  logic [15:0] a_q, b_q;
  logic [1:0]  a_addr;
  logic [9:0]  b_addr;
  logic [15:0] a_data, b_data, a_entry, b_entry;
  logic        a_we, b_we, a_busy, b_busy, a_err, b_err;
  logic [1:0]  a_nib, b_nib;

  ram_nibble_writer #(.ADDR_W(2), .RD_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .key_n(a_key), .sw(a_sw),
    .addr_rst(a_arst), .q_a(a_q), .addr_a(a_addr), .data_a(a_data),
    .we_a(a_we), .entry(a_entry), .nib_idx(a_nib), .busy(a_busy),
    .verify_err(a_err));

  ram_nibble_writer #(.ADDR_W(10), .RD_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .key_n(b_key), .sw(b_sw),
    .addr_rst(b_arst), .q_a(b_q), .addr_a(b_addr), .data_a(b_data),
    .we_a(b_we), .entry(b_entry), .nib_idx(b_nib), .busy(b_busy),
    .verify_err(b_err));

  // RAM models; a corrupt flag stores a wrong word at write time
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [1024];
  logic [15:0] qp_b [3];
  bit corrupt_a = 0, corrupt_b = 0;
  logic [31:0] wq_a[$], wq_b[$];

  always @(posedge clk) begin
    if (a_we) begin
      mem_a[a_addr] <= corrupt_a ? 16'h1234 : a_data;
      wq_a.push_back({14'd0, a_addr, a_data});
    end
    a_q <= mem_a[a_addr];
    if (b_we) begin
      mem_b[b_addr] <= corrupt_b ? ~b_data : b_data;
      wq_b.push_back({6'd0, b_addr, b_data});
    end
    qp_b[0] <= mem_b[b_addr];
    qp_b[1] <= qp_b[0];
    qp_b[2] <= qp_b[1];
  end
  assign b_q = qp_b[2];

  // busy run-length monitors
  int run_a = 0, last_a = 0, run_b = 0, last_b = 0;
  always @(negedge clk) begin
    if (a_busy) run_a <= run_a + 1;
    else if (run_a != 0) begin last_a <= run_a; run_a <= 0; end
    if (b_busy) run_b <= run_b + 1;
    else if (run_b != 0) begin last_b <= run_b; run_b <= 0; end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input bit sel, input logic [3:0] nib);
    @(negedge clk);
    if (sel) begin b_key = 0; b_sw = nib; end
    else begin a_key = 0; a_sw = nib; end
    repeat (2) @(negedge clk);
    if (sel) b_key = 1; else a_key = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while ((sel ? b_busy : a_busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, sel ? b_busy : a_busy}, 0);
    @(negedge clk);
  endtask

  task automatic enter_word(input bit sel, input logic [15:0] w);
    press(sel, w[15:12]);
    press(sel, w[11:8]);
    press(sel, w[7:4]);
    press(sel, w[3:0]);
    wait_idle(sel);
  endtask

  task automatic pulse_arst(input bit sel);
    @(negedge clk);
    if (sel) b_arst = 1; else a_arst = 1;
    @(negedge clk);
    if (sel) b_arst = 0; else a_arst = 0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic [15:0] entry;
    logic [1:0]  nib;
  } vec_t;

  vec_t tbl[4];
  logic [15:0] words[4];
  logic [1:0]  wr_addr[5];

  // behavioural model for instance B
  logic [15:0] m_entry;
  int          m_nib, m_addr;
  bit          m_err;

  initial begin
    int n;
    logic [31:0] rec;
    tbl[0] = '{4'hA, 16'h000A, 2'd1};
    tbl[1] = '{4'hB, 16'h00AB, 2'd2};
    tbl[2] = '{4'hC, 16'h0ABC, 2'd3};
    tbl[3] = '{4'hD, 16'hABCD, 2'd0};
    words[0] = 16'hABCD; words[1] = 16'h5678;
    words[2] = 16'h0F0F; words[3] = 16'hC3A5;
    wr_addr[0] = 0; wr_addr[1] = 1; wr_addr[2] = 2;
    wr_addr[3] = 3; wr_addr[4] = 0;

    #12;
    chk("rst_a_entry", a_entry, 0);
    chk("rst_a_nib", a_nib, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_we", a_we, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_b_entry", b_entry, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);

    // basic entry on A
    for (int i = 0; i < 4; i++) begin
      press(0, tbl[i].sw);
      chk($sformatf("basic_entry%0d", i), a_entry, tbl[i].entry);
      chk($sformatf("basic_nib%0d", i), a_nib, tbl[i].nib);
      chk($sformatf("basic_data%0d", i), a_data, tbl[i].entry);
    end
    wait_idle(0);
    chk("basic_wcount", wq_a.size(), 1);
    rec = wq_a.pop_front();
    chk("basic_wrec", rec, {16'd0, 16'hABCD});
    chk("basic_addr", a_addr, 1);
    chk("basic_err", a_err, 0);
    chk("basic_busy_len", last_a, 3);

    // mismatch on 2nd word, sticky through later words, wrap on 5th
    for (int i = 0; i < 4; i++) begin
      corrupt_a = (i == 0);
      enter_word(0, words[i]);
      corrupt_a = 0;
      chk($sformatf("seq_err%0d", i), a_err, 1);
      chk($sformatf("seq_entry%0d", i), a_entry, words[i]);
    end
    chk("wrap_wcount", wq_a.size(), 4);
    for (int i = 1; i < 5; i++) begin
      rec = wq_a.pop_front();
      chk($sformatf("wrap_addr%0d", i), rec[17:16], wr_addr[i]);
      chk($sformatf("wrap_data%0d", i), rec[15:0], words[i-1]);
    end
    chk("wrap_mem0", mem_a[0], 16'hC3A5);
    chk("wrap_addr_after", a_addr, 1);
    pulse_arst(0);
    chk("arst_err", a_err, 0);
    chk("arst_addr", a_addr, 0);
    chk("arst_entry", a_entry, 16'hC3A5);

    // press landing in CHECK must be dropped
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3);
    @(negedge clk); a_key = 0; a_sw = 4'h4;
    repeat (2) @(negedge clk); a_key = 1;
    @(negedge clk); a_key = 0;
    @(negedge clk); a_sw = 4'hF;
    @(negedge clk); a_key = 1;
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("drop_nib", a_nib, 0);
    chk("drop_entry", a_entry, 16'h1234);
    chk("drop_addr", a_addr, 1);
    chk("drop_wcount", wq_a.size(), 1);
    rec = wq_a.pop_front();
    chk("drop_wrec", rec, {16'd0, 16'h1234});

    // simultaneous addr_rst and press at nib_idx=2
    press(0, 4'h9); press(0, 4'h8);
    chk("sim_pre_nib", a_nib, 2);
    @(negedge clk); a_key = 0; a_sw = 4'h7;
    repeat (2) @(negedge clk); a_key = 1;
    @(negedge clk); a_arst = 1;
    @(negedge clk); a_arst = 0;
    repeat (2) @(negedge clk);
    chk("sim_nib", a_nib, 0);
    chk("sim_addr", a_addr, 0);
    chk("sim_entry", a_entry, 16'h3498);

    // reset while WRITE: we_a must drop without a clock
    press(0, 4'h5); press(0, 4'h6); press(0, 4'h7);
    @(negedge clk); a_key = 0; a_sw = 4'h8;
    n = 0;
    while (!a_we && n < 20) begin @(negedge clk); n++; end
    chk("midw_we_seen", a_we, 1);
    #3 reset_n = 0;
    #1;
    chk("midw_we", a_we, 0);
    chk("midw_busy", a_busy, 0);
    chk("midw_entry", a_entry, 0);
    chk("midw_nib", a_nib, 0);
    chk("midw_addr", a_addr, 0);
    chk("midw_err", a_err, 0);
    a_key = 1;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    press(0, 4'h1);
    chk("post_rst_entry", a_entry, 16'h0001);
    chk("post_rst_nib", a_nib, 1);

    // instance B: longer read latency
    wq_b.delete();
    enter_word(1, 16'hBEEF);
    chk("b_busy_len", last_b, 5);
    chk("b_wcount", wq_b.size(), 1);
    rec = wq_b.pop_front();
    chk("b_wrec", rec, {16'd0, 16'hBEEF});
    chk("b_addr", b_addr, 1);
    chk("b_err", b_err, 0);

    // randomized sequence against a word-level model
    m_entry = 16'hBEEF; m_nib = 0; m_addr = 1; m_err = 0;
    for (int it = 0; it < 80; it++) begin
      logic [3:0] nb;
      bit bad;
      if ($urandom_range(0, 11) == 0) begin
        pulse_arst(1);
        m_addr = 0; m_nib = 0; m_err = 0;
      end else begin
        nb = 4'($urandom_range(0, 15));
        bad = (m_nib == 3) && ($urandom_range(0, 5) == 0);
        corrupt_b = bad;
        press(1, nb);
        m_entry = {m_entry[11:0], nb};
        m_nib = m_nib + 1;
        if (m_nib == 4) begin
          wait_idle(1);
          corrupt_b = 0;
          m_nib = 0;
          chk("rnd_wcount", wq_b.size(), 1);
          rec = wq_b.pop_front();
          chk("rnd_wrec", rec, {6'd0, 10'(m_addr), m_entry});
          if (bad) m_err = 1;
          m_addr = (m_addr + 1) % 1024;
        end
      end
      chk("rnd_entry", b_entry, m_entry);
      chk("rnd_nib", b_nib, m_nib);
      chk("rnd_addr", b_addr, m_addr);
      chk("rnd_err", b_err, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
